// File: rtl/mix_columns_engine.sv
// AES MixColumns/InvMixColumns stage, COLS_PER_CYCLE columns per falling edge; out_valid rises 4/CPC edges after accept.
// Output holds in DONE until out_ready; a new block can be taken on the same edge that the old one leaves.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit SUPPORT_INV    = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int          NGRP     = (COLS_PER_CYCLE > 0) ? 4 / COLS_PER_CYCLE : 1;
    localparam int          W        = 32 * COLS_PER_CYCLE;
    localparam logic [1:0]  LAST_GRP = 2'(NGRP - 1);
    localparam logic [127:0] MASK    = (W >= 128) ? '1 : ((128'd1 << W) - 128'd1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state, state_nxt;
    logic [1:0]   grp;
    logic [127:0] blk;
    logic         inv_q;
    logic         accept;
    logic [6:0]   shamt;
    logic [127:0] sel, mixed_flat, out_nxt;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Constant multiplier built from an xtime chain; k selects the 1/2/4/8 terms.
    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] k);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return (k[0] ? b : 8'h00) ^ (k[1] ? b2 : 8'h00) ^ (k[2] ? b4 : 8'h00) ^ (k[3] ? b8 : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        if (inv)
            return {gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9),
                    gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd),
                    gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb),
                    gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he)};
        else
            return {gmul(a0, 4'h2) ^ gmul(a1, 4'h3) ^ a2 ^ a3,
                    a0 ^ gmul(a1, 4'h2) ^ gmul(a2, 4'h3) ^ a3,
                    a0 ^ a1 ^ gmul(a2, 4'h2) ^ gmul(a3, 4'h3),
                    gmul(a0, 4'h3) ^ a1 ^ a2 ^ gmul(a3, 4'h2)};
    endfunction

    // Only COLS_PER_CYCLE mixers exist; the active group is shifted down to them and back up.
    assign shamt = 7'(int'(grp) * W);
    assign sel   = blk >> shamt;

    generate
        for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_mix
            assign mixed_flat[k*32 +: 32] = mix_col(sel[k*32 +: 32], inv_q);
        end
        if (W < 128) begin : g_pad
            assign mixed_flat[127:W] = '0;
        end
    endgenerate

    assign out_nxt = (out_data & ~(MASK << shamt)) | (mixed_flat << shamt);
    assign accept  = in_valid && in_ready;

    always_ff @(negedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (grp == LAST_GRP) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !reset && (state == IDLE || (state == DONE && out_ready));
        out_valid = (state == DONE);
        busy      = (state == BUSY);
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            grp      <= '0;
            blk      <= '0;
            inv_q    <= 1'b0;
            out_data <= '0;
        end else if (accept) begin
            grp   <= '0;
            blk   <= in_data;
            inv_q <= in_inv & SUPPORT_INV;
        end else if (state == BUSY) begin
            out_data <= out_nxt;
            grp      <= grp + 2'd1;
        end
    end
endmodule

// File: tb/tb_mix_columns_engine.sv
// Drives CPC=1/2/4 engines with shared stimulus; a per-instance scoreboard checks data, latency and handshakes.
module tb_mix_columns_engine;
    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid, in_inv, out_ready;
    logic [127:0] in_data;
    logic         ir [3];
    logic         ov [3];
    logic         bz [3];
    logic [127:0] od [3];

    always #5 clk = ~clk;

    mix_columns_engine #(.COLS_PER_CYCLE(1), .SUPPORT_INV(1)) u_c1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bz[0]));
    mix_columns_engine #(.COLS_PER_CYCLE(2), .SUPPORT_INV(1)) u_c2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bz[1]));
    mix_columns_engine #(.COLS_PER_CYCLE(4), .SUPPORT_INV(1)) u_c4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
        .in_inv(in_inv), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bz[2]));

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           acc_cnt [3] = '{0, 0, 0};
    int           out_cnt [3] = '{0, 0, 0};
    int           last_acc[3] = '{0, 0, 0};
    int           lat_exp [3] = '{5, 3, 2};
    logic         prev_v  [3];
    logic         hold_v  [3];
    logic [127:0] hold_d  [3];
    logic [127:0] last_out[3];
    logic [127:0] exp_q   [3][$];
    bit           directed = 1'b0;
    logic [127:0] cur_exp  = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] d, input logic inv);
        logic [7:0]   base [4];
        logic [127:0] r;
        logic [31:0]  col;
        logic [7:0]   acc;
        logic [1:0]   idx;
        if (inv) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     base = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            col = 32'(d >> (32 * c));
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    idx = 2'(j - i);
                    acc ^= ref_mul(8'(col >> (24 - 8 * j)), base[idx]);
                end
                r |= 128'(acc) << (32 * c + 24 - 8 * i);
            end
        end
        return r;
    endfunction

    // Scoreboard/monitor: samples 2 time units after each rising edge (DUT state moves on falling edges).
    always @(posedge clk) begin
        #2;
        cyc++;
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                check($sformatf("rst_in_ready%0d", k), 128'(ir[k]), 128'(0));
                check($sformatf("rst_out_valid%0d", k), 128'(ov[k]), 128'(0));
                check($sformatf("rst_busy%0d", k), 128'(bz[k]), 128'(0));
                check($sformatf("rst_out_data%0d", k), od[k], 128'(0));
                exp_q[k].delete();
                hold_v[k]  = 1'b0;
                prev_v[k]  = 1'b0;
                acc_cnt[k] = 0;
                out_cnt[k] = 0;
            end else begin
                if (hold_v[k]) begin
                    check($sformatf("hold_valid%0d", k), 128'(ov[k]), 128'(1));
                    check($sformatf("hold_data%0d", k), od[k], hold_d[k]);
                end
                if (bz[k]) check($sformatf("ready_in_busy%0d", k), 128'(ir[k]), 128'(0));
                if (ov[k] && !prev_v[k])
                    check($sformatf("latency%0d", k), 128'(cyc - last_acc[k]), 128'(lat_exp[k]));
                if (ov[k] && out_ready) begin
                    if (exp_q[k].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_out%0d: got %0h, expected no block", k, od[k]);
                    end else begin
                        check($sformatf("out_data%0d", k), od[k], exp_q[k].pop_front());
                    end
                    out_cnt[k]++;
                    last_out[k] = od[k];
                end
                if (in_valid && ir[k]) begin
                    exp_q[k].push_back(directed ? cur_exp : ref_model(in_data, in_inv));
                    acc_cnt[k]++;
                    last_acc[k] = cyc;
                end
                hold_v[k] = ov[k] && !out_ready;
                hold_d[k] = od[k];
                prev_v[k] = ov[k];
            end
        end
    end

    typedef struct {
        logic [127:0] d;
        logic         inv;
        logic [127:0] e;
    } vec_t;

    task automatic send(input logic [127:0] d, input logic inv, input bit dir, input logic [127:0] e);
        @(posedge clk);
        in_valid = 1'b1; in_data = d; in_inv = inv; directed = dir; cur_exp = e;
        @(posedge clk);
        // Scramble inputs after accept; the captured block must be unaffected.
        in_valid = 1'b0; in_data = {$urandom(), $urandom(), $urandom(), $urandom()}; in_inv = ~inv;
        repeat (6) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tab [7];
        logic [127:0] x, y;
        int           start, guard;

        tab[0] = '{{32'h2d26314c, 32'hd4d4d4d5, 32'hf20a225c, 32'hdb135345}, 1'b0,
                   {32'h4d7ebdf8, 32'hd5d5d7d6, 32'h9fdc589d, 32'h8e4da1bc}};
        tab[1] = '{{32'h4d7ebdf8, 32'hd5d5d7d6, 32'h9fdc589d, 32'h8e4da1bc}, 1'b1,
                   {32'h2d26314c, 32'hd4d4d4d5, 32'hf20a225c, 32'hdb135345}};
        tab[2] = '{{4{32'h01010101}}, 1'b0, {4{32'h01010101}}};
        tab[3] = '{{4{32'h01010101}}, 1'b1, {4{32'h01010101}}};
        tab[4] = '{{4{32'hc6c6c6c6}}, 1'b0, {4{32'hc6c6c6c6}}};
        tab[5] = '{{4{32'hc6c6c6c6}}, 1'b1, {4{32'hc6c6c6c6}}};
        tab[6] = '{128'h0, 1'b1, 128'h0};

        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        reset = 1'b0;
        #3;
        for (int k = 0; k < 3; k++) check($sformatf("idle_ready%0d", k), 128'(ir[k]), 128'(1));

        for (int i = 0; i < 7; i++) send(tab[i].d, tab[i].inv, 1'b1, tab[i].e);

        // Round trip through the engines: inverse of the forward result must restore x.
        for (int i = 0; i < 3; i++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            send(x, 1'b0, 1'b0, '0);
            y = last_out[0];
            send(y, 1'b1, 1'b1, x);
        end

        // Backpressure in DONE, then handshake and accept on the same edge.
        @(posedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; directed = 1'b0;
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #3;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_ready%0d", k), 128'(ir[k]), 128'(0));
            check($sformatf("bp_valid%0d", k), 128'(ov[k]), 128'(1));
        end
        @(posedge clk);
        out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b1;
        in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        #3;
        for (int k = 0; k < 3; k++) check($sformatf("bp_accept%0d", k), 128'(ir[k]), 128'(1));
        @(posedge clk);
        in_valid = 1'b0;
        #3;
        for (int k = 0; k < 3; k++) check($sformatf("bp_no_idle%0d", k), 128'(bz[k]), 128'(1));
        repeat (6) @(posedge clk);

        // Reset after two groups of the CPC=1 engine.
        @(posedge clk);
        in_valid = 1'b1; in_inv = 1'b0; in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        check("mid_busy", 128'(bz[0]), 128'(1));
        @(posedge clk);
        reset = 1'b1;
        #1;
        check("async_rst_valid", 128'(ov[0]), 128'(0));
        check("async_rst_data", od[0], 128'(0));
        check("async_rst_busy", 128'(bz[0]), 128'(0));
        @(posedge clk);
        reset = 1'b0;
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, 1'b0, '0);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b0, '0);

        // Random traffic with stalls on both sides.
        start = acc_cnt[0];
        guard = 0;
        while (acc_cnt[0] - start < 1000 && guard < 20000) begin
            @(posedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_inv    = 1'($urandom_range(0, 1));
            in_data   = {$urandom(), $urandom(), $urandom(), $urandom()};
            guard++;
        end
        check("random_blocks", 128'(acc_cnt[0] - start >= 1000), 128'(1));
        @(posedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #3;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("count_in_out%0d", k), 128'(out_cnt[k]), 128'(acc_cnt[k]));
            check($sformatf("drained%0d", k), 128'(exp_q[k].size()), 128'(0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
